line_window_buffer: RTL and testbench
=====================================

# line_window_buffer

Parametrised AXI4-Stream line buffer that turns a raster pixel stream into vertically aligned K-pixel columns for the convolution kernel shift registers. It stores the previous K-1 image lines in one wide circular line memory. It tracks row and column position with SOF/EOL framing and per-tap validity masking for top-border rows. It supports full backpressure on both sides, and detects and recovers from framing errors.

## Interface
Parameters:
- IMAGE_COLUMN, 512: pixels per line, ≥ 4.
- IMAGE_ROW, 512: lines per frame, ≥ 2.
- IMAGE_DATA_WIDTH, 8: pixel width W.
- CONV_KERNEL_SIZE, 11: taps K, odd, 3..31; line memory holds K-1 lines.
- Derived: COL_W = clog2(IMAGE_COLUMN), ROW_W = clog2(IMAGE_ROW).

Ports:
- axi_clk  in  1  clock.
- axi_rstn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  W  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of line.
- s_axis_tuser  in  1  start of frame (first pixel).
- m_axis_tdata  out  K×W packed [K-1:0][W-1:0]  tap i = pixel at (row r−i, col c); tap 0 = current pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  col == IMAGE_COLUMN−1.
- m_axis_tuser  out  1  row == 0 and col == 0.
- m_axis_row_valid  out  K  bit i = (r ≥ i).
- m_axis_row  out  ROW_W  row r of tap 0.
- m_axis_col  out  COL_W  column c.
- err_line  out  1  sticky: tlast position mismatch.
- err_frame  out  1  sticky: SOF received mid-frame.
- err_clr  in  1  synchronous clear of both sticky errors.

## Operation
- Accept = s_axis_tvalid & s_axis_tready.
- s_axis_tready = !stage1_valid | stage1_advance. A stage advances when the next stage is empty or being drained.
- States:
  - WAIT_SOF: accept and discard pixels without tuser. An accepted pixel with tuser enters RUN with col = 0, row = 0, and that pixel is processed.
  - RUN: col increments per accept. At col == IMAGE_COLUMN−1: col ← 0, row increments. After the last pixel of row IMAGE_ROW−1, return to WAIT_SOF.
- Line memory: single RAM, depth IMAGE_COLUMN, width (K−1)·W, read-first with synchronous read and read-enable = accept. Dout holds while read-enable is low.
  - On accept at col c, read word[c].
  - In the following cycle (stage 1 load), write word[c] ← {rd[K−3:0], pixel}. The write is unconditional and independent of downstream stall.
  - Slot j of the word holds row r−1−j.
- Output taps: tap 0 = pixel; tap i = rd slot i−1.
- Any tap with row_valid[i] = 0 is forced to 0, which implements zero padding and masks stale or uninitialised memory.
- Framing errors:
  - tlast accepted with col ≠ IMAGE_COLUMN−1: set err_line and treat the pixel as end of line (col ← 0, row++).
  - Missing tlast at col == IMAGE_COLUMN−1: set err_line and wrap anyway.
  - tuser accepted in RUN when not (row == 0 and col == 0): set err_frame and restart at row 0, col 0 with that pixel.
  - Error and restart pixels are still output with their recomputed coordinates.
- If err_clr and a new error occur in the same cycle, the new error wins (bit set).

## Timing
- Two-stage pipeline. A pixel accepted at cycle t appears on m_axis at t+2 with no stall. Throughput is 1 pixel/clk sustained.
- AXIS rules:
  - m_axis_tvalid, once high, stays high with all m_axis fields stable until m_axis_tready.
  - s_axis_tready may drop only in response to downstream stall. With m_axis_tready held low, at most 2 pixels are accepted.
- Reset (axi_rstn low, asynchronous assert, synchronous deassert externally):
  - Outputs: m_axis_tvalid = 0, s_axis_tready = 0 while in reset and 1 from the first cycle after release. All m_axis data and coordinate outputs = 0; err_line = err_frame = 0.
  - State = WAIT_SOF. RAM contents are not cleared.
- Reset mid-frame: the in-flight pipeline is discarded and the next frame needs a new SOF.

## Test plan
- 8×4 image, K = 3, pixel = row·16 + col, continuous valid, tready = 1. Required response:
  - Row 0 outputs: taps {v, 0, 0}, row_valid = 001.
  - Row 2 col 5: taps {0x25, 0x15, 0x05}, row_valid = 111.
  - tlast on each col 7; tuser only on the first output.
  - Latency 2.
- Same image with random m_axis_tready (50%): output sequence identical to the no-stall run, no drops or duplicates, fields stable while stalled.
- Three pixels without tuser, then SOF: the first three are discarded, the first output is row 0 col 0 with tuser = 1, and no error is flagged.
- tlast at col 5 of row 1: err_line = 1. The next pixel is output as row 2 col 0. err_clr clears the flag.
- tuser at row 2 col 3: err_frame = 1, that pixel is output as row 0 col 0 with row_valid = 001, and the next frame proceeds normally.
- axi_rstn asserted at row 1 col 4 with output stalled: m_axis_tvalid drops to 0 immediately. After release, pixels before a new SOF are discarded. The new frame's row 0 outputs have taps 1..K−1 = 0.

Source files
------------

// File: rtl/line_window_buffer.sv
// AXI4-Stream line buffer: turns a raster pixel stream into vertically aligned
// K-pixel columns, with top-border masking, framing checks and full backpressure.
module line_window_buffer #(
    parameter  int IMAGE_COLUMN     = 512,
    parameter  int IMAGE_ROW        = 512,
    parameter  int IMAGE_DATA_WIDTH = 8,
    parameter  int CONV_KERNEL_SIZE = 11,
    localparam int COL_W            = $clog2(IMAGE_COLUMN),
    localparam int ROW_W            = $clog2(IMAGE_ROW)
) (
    input  logic                                                axi_clk,
    input  logic                                                axi_rstn,
    input  logic [IMAGE_DATA_WIDTH-1:0]                         s_axis_tdata,
    input  logic                                                s_axis_tvalid,
    output logic                                                s_axis_tready,
    input  logic                                                s_axis_tlast,
    input  logic                                                s_axis_tuser,
    output logic [CONV_KERNEL_SIZE-1:0][IMAGE_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                                                m_axis_tvalid,
    input  logic                                                m_axis_tready,
    output logic                                                m_axis_tlast,
    output logic                                                m_axis_tuser,
    output logic [CONV_KERNEL_SIZE-1:0]                         m_axis_row_valid,
    output logic [ROW_W-1:0]                                    m_axis_row,
    output logic [COL_W-1:0]                                    m_axis_col,
    output logic                                                err_line,
    output logic                                                err_frame,
    input  logic                                                err_clr
);

    localparam int W  = IMAGE_DATA_WIDTH;
    localparam int K  = CONV_KERNEL_SIZE;
    localparam int MW = (K - 1) * W;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_COLUMN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_ROW - 1);

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [COL_W-1:0]   col_r, col_nxt_s, pix_col_s;
    logic [ROW_W-1:0]   row_r, row_nxt_s, pix_row_s;
    logic               proc_s, restart_s, at_last_s;
    logic               set_err_line_s, set_err_frame_s;
    logic               accept_s, s1_advance_s;
    logic               run_en_r;

    logic               s1_valid_r;
    logic [W-1:0]       s1_pix_r;
    logic [ROW_W-1:0]   s1_row_r;
    logic [COL_W-1:0]   s1_col_r;
    logic               wr_en_r;
    logic [MW-1:0]      rd_r;
    logic [MW-1:0]      mem [IMAGE_COLUMN];

    logic [K-1:0][W-1:0] taps_s;
    logic [K-1:0]        rv_s;

    logic                out_valid_r;
    logic [K-1:0][W-1:0] out_data_r;
    logic [K-1:0]        out_rv_r;
    logic [ROW_W-1:0]    out_row_r;
    logic [COL_W-1:0]    out_col_r;
    logic                out_last_r;
    logic                out_user_r;
    logic                err_line_r;
    logic                err_frame_r;

    assign accept_s      = s_axis_tvalid & s_axis_tready;
    assign s1_advance_s  = s1_valid_r & (~out_valid_r | m_axis_tready);
    assign s_axis_tready = run_en_r & (~s1_valid_r | s1_advance_s);

    // Frame-position FSM: coordinates of the accepted pixel and of the next one.
    always_comb begin
        state_nxt_s     = state_r;
        col_nxt_s       = col_r;
        row_nxt_s       = row_r;
        proc_s          = 1'b0;
        restart_s       = 1'b0;
        set_err_line_s  = 1'b0;
        set_err_frame_s = 1'b0;
        case (state_r)
            WAIT_SOF: begin
                if (accept_s && s_axis_tuser) begin
                    proc_s    = 1'b1;
                    restart_s = 1'b1;
                end else begin
                    proc_s    = 1'b0;
                end
            end
            RUN: begin
                if (accept_s) begin
                    proc_s          = 1'b1;
                    restart_s       = s_axis_tuser;
                    set_err_frame_s = s_axis_tuser &
                                      ~((row_r == ROW_W'(0)) && (col_r == COL_W'(0)));
                end else begin
                    proc_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = WAIT_SOF;
            end
        endcase

        if (restart_s) begin
            pix_col_s = COL_W'(0);
            pix_row_s = ROW_W'(0);
        end else begin
            pix_col_s = col_r;
            pix_row_s = row_r;
        end
        at_last_s = (pix_col_s == COL_LAST);

        // A stray or missing tlast still ends the line, so the raster stays aligned.
        if (proc_s) begin
            set_err_line_s = (s_axis_tlast != at_last_s);
            if (s_axis_tlast || at_last_s) begin
                col_nxt_s = COL_W'(0);
                if (pix_row_s == ROW_LAST) begin
                    row_nxt_s   = ROW_W'(0);
                    state_nxt_s = WAIT_SOF;
                end else begin
                    row_nxt_s   = pix_row_s + ROW_W'(1);
                    state_nxt_s = RUN;
                end
            end else begin
                col_nxt_s   = pix_col_s + COL_W'(1);
                row_nxt_s   = pix_row_s;
                state_nxt_s = RUN;
            end
        end else begin
            set_err_line_s = 1'b0;
        end
    end

    // Position state, input enable after reset, and sticky error flags.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state_r     <= WAIT_SOF;
            col_r       <= COL_W'(0);
            row_r       <= ROW_W'(0);
            run_en_r    <= 1'b0;
            err_line_r  <= 1'b0;
            err_frame_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            col_r    <= col_nxt_s;
            row_r    <= row_nxt_s;
            run_en_r <= 1'b1;
            if (set_err_line_s) begin
                err_line_r <= 1'b1;
            end else if (err_clr) begin
                err_line_r <= 1'b0;
            end
            if (set_err_frame_s) begin
                err_frame_r <= 1'b1;
            end else if (err_clr) begin
                err_frame_r <= 1'b0;
            end
        end
    end

    // Stage 1: the accepted pixel waits here alongside its line-memory read word.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            s1_valid_r <= 1'b0;
            s1_pix_r   <= '0;
            s1_row_r   <= ROW_W'(0);
            s1_col_r   <= COL_W'(0);
            wr_en_r    <= 1'b0;
        end else begin
            wr_en_r <= proc_s;
            if (proc_s) begin
                s1_valid_r <= 1'b1;
                s1_pix_r   <= s_axis_tdata;
                s1_row_r   <= pix_row_s;
                s1_col_r   <= pix_col_s;
            end else if (s1_advance_s) begin
                s1_valid_r <= 1'b0;
            end
        end
    end

    // Read-first line memory; the write-back happens once, on the stage-1 load cycle.
    always_ff @(posedge axi_clk) begin
        if (accept_s) begin
            rd_r <= mem[pix_col_s];
        end
        if (wr_en_r) begin
            mem[s1_col_r] <= {rd_r[MW-W-1:0], s1_pix_r};
        end
    end

    // Tap assembly with top-border masking (also hides stale memory contents).
    always_comb begin
        taps_s    = '0;
        rv_s      = '0;
        rv_s[0]   = 1'b1;
        taps_s[0] = s1_pix_r;
        for (int i = 1; i < K; i++) begin
            rv_s[i] = (int'(s1_row_r) >= i);
            if (rv_s[i]) begin
                taps_s[i] = rd_r[(i-1)*W +: W];
            end else begin
                taps_s[i] = '0;
            end
        end
    end

    // Stage 2: output register, held stable while the sink stalls.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_rv_r    <= '0;
            out_row_r   <= ROW_W'(0);
            out_col_r   <= COL_W'(0);
            out_last_r  <= 1'b0;
            out_user_r  <= 1'b0;
        end else if (s1_advance_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= taps_s;
            out_rv_r    <= rv_s;
            out_row_r   <= s1_row_r;
            out_col_r   <= s1_col_r;
            out_last_r  <= (s1_col_r == COL_LAST);
            out_user_r  <= (s1_row_r == ROW_W'(0)) && (s1_col_r == COL_W'(0));
        end else if (m_axis_tready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign m_axis_tvalid    = out_valid_r;
    assign m_axis_tdata     = out_data_r;
    assign m_axis_row_valid = out_rv_r;
    assign m_axis_row       = out_row_r;
    assign m_axis_col       = out_col_r;
    assign m_axis_tlast     = out_last_r;
    assign m_axis_tuser     = out_user_r;
    assign err_line         = err_line_r;
    assign err_frame        = err_frame_r;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer on an 8x4 image with a 3-tap kernel.
module tb_line_window_buffer;

    logic              clk;
    logic              rstn;
    logic [7:0]        s_tdata;
    logic              s_tvalid, s_tready, s_tlast, s_tuser;
    logic [2:0][7:0]   m_tdata;
    logic              m_tvalid, m_tready, m_tlast, m_tuser;
    logic [2:0]        m_rv;
    logic [1:0]        m_row;
    logic [2:0]        m_col;
    logic              err_line, err_frame, err_clr;

    line_window_buffer #(
        .IMAGE_COLUMN(8), .IMAGE_ROW(4), .IMAGE_DATA_WIDTH(8), .CONV_KERNEL_SIZE(3)
    ) dut (
        .axi_clk(clk), .axi_rstn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_row_valid(m_rv),
        .m_axis_row(m_row), .m_axis_col(m_col),
        .err_line(err_line), .err_frame(err_frame), .err_clr(err_clr)
    );

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic        user;
        logic [33:0] exp;
    } vec_t;

    typedef struct {
        logic [33:0] vec;
        int          cyc;
    } out_t;

    vec_t        vecs [32];
    logic [7:0]  img [4][8];
    out_t        got [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          sof_cyc = 0;
    int          acc_cnt = 0;
    bit          rand_rdy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] cur_vec();
        return {m_tdata, m_rv, m_row, m_col, m_tlast, m_tuser};
    endfunction

    // expected output for pixel (r,c): tap i = img[r-i][c] when r >= i, else 0
    function automatic logic [33:0] exp_vec(int r, int c);
        logic [23:0] d;
        logic [2:0]  rv;
        d  = 24'h0;
        rv = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (r >= i) begin
                d[i*8 +: 8] = img[r-i][c];
                rv[i]       = 1'b1;
            end
        end
        return {d, rv, 2'(r), 3'(c), (c == 7), (r == 0 && c == 0)};
    endfunction

    // monitor: capture handshakes, count accepts, check output stability under stall
    initial begin
        bit          stalled;
        logic [33:0] held;
        stalled = 1'b0;
        held    = 34'h0;
        forever begin
            @(posedge clk);
            if (rstn) begin
                if (stalled) check("stall stable", {m_tvalid, cur_vec()}, {1'b1, held});
                stalled = m_tvalid && !m_tready;
                held    = cur_vec();
                if (m_tvalid && m_tready) got.push_back('{vec: cur_vec(), cyc: cyc});
                if (s_tvalid && s_tready) begin
                    acc_cnt++;
                    if (s_tuser) sof_cyc = cyc;
                end
            end else begin
                stalled = 1'b0;
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d, input logic l, input logic u);
        bit done;
        done     = 1'b0;
        s_tdata  = d;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            #1;
            if (s_tready) done = 1'b1;
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        check("send accepted", done, 1'b1);
    endtask

    task automatic fill_img(input int off);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = 8'(off + r * 16 + c);
    endtask

    task automatic make_vecs();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) begin
                vecs[r*8+c].data = img[r][c];
                vecs[r*8+c].last = (c == 7);
                vecs[r*8+c].user = (r == 0 && c == 0);
                vecs[r*8+c].exp  = exp_vec(r, c);
            end
    endtask

    task automatic send_range(input int from, input int to);
        for (int i = from; i <= to; i++) send(vecs[i].data, vecs[i].last, vecs[i].user);
    endtask

    task automatic wait_out(input int n, input string tag);
        for (int k = 0; k < 300 && got.size() < n; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check({tag, " output count"}, got.size(), n);
    endtask

    task automatic check_vecs(input int base, input string tag);
        for (int i = 0; i < 32; i++) begin
            if (base + i < got.size())
                check($sformatf("%s px%0d", tag, i), got[base+i].vec, vecs[i].exp);
            else
                check($sformatf("%s px%0d missing", tag, i), 1'b0, 1'b1);
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
    endtask

    initial begin
        rstn = 1'b1; m_tready = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00;
        s_tlast = 1'b0; s_tuser = 1'b0; err_clr = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tvalid", m_tvalid, 1'b0);
        check("rst tready", s_tready, 1'b0);
        check("rst outputs", {m_tdata, m_rv, m_row, m_col, m_tlast, m_tuser}, 34'h0);
        check("rst errors", {err_line, err_frame}, 2'b00);
        rstn = 1'b1;
        @(negedge clk); #1;
        check("tready after rst", s_tready, 1'b1);

        // T1: clean frame, no stall
        fill_img(0); make_vecs(); got.delete();
        send_range(0, 31);
        wait_out(32, "t1");
        check_vecs(0, "t1");
        check("t1 row0col3", {got[3].vec[33:10], got[3].vec[9:7]}, {24'h000003, 3'b001});
        check("t1 row2col5", {got[21].vec[33:10], got[21].vec[9:7]}, {24'h051525, 3'b111});
        check("t1 latency", got[0].cyc - sof_cyc, 2);
        check("t1 errors", {err_line, err_frame}, 2'b00);

        // T2: same frame with random sink backpressure
        got.delete(); rand_rdy = 1'b1;
        send_range(0, 31);
        wait_out(32, "t2");
        rand_rdy = 1'b0; m_tready = 1'b1;
        check_vecs(0, "t2");

        // T3: pixels before SOF are dropped silently
        fill_img(8'h40); make_vecs(); got.delete();
        send(8'hE1, 1'b0, 1'b0); send(8'hE2, 1'b0, 1'b0); send(8'hE3, 1'b1, 1'b0);
        send_range(0, 31);
        wait_out(32, "t3");
        check_vecs(0, "t3");
        check("t3 errors", {err_line, err_frame}, 2'b00);

        // T4: early tlast at row 1 col 5
        fill_img(0); make_vecs(); got.delete();
        send_range(0, 12);
        send(8'h15, 1'b1, 1'b0);
        check("t4 err_line set", err_line, 1'b1);
        send(8'h20, 1'b0, 1'b0);
        send_range(17, 31);
        wait_out(30, "t4");
        check("t4 row1col5", got[13].vec[6:0], {2'd1, 3'd5, 1'b0, 1'b0});
        check("t4 row2col0", got[14].vec, {24'h001020, 3'b111, 2'd2, 3'd0, 1'b0, 1'b0});
        check("t4 sticky", {err_line, err_frame}, 2'b10);
        pulse_clr();
        check("t4 cleared", {err_line, err_frame}, 2'b00);

        // T5: SOF at row 2 col 3 restarts the frame
        fill_img(0); make_vecs(); got.delete();
        send_range(0, 18);
        send(8'h77, 1'b0, 1'b1);
        check("t5 err_frame set", {err_line, err_frame}, 2'b01);
        img[0][0] = 8'h77; make_vecs();
        send_range(1, 31);
        wait_out(51, "t5");
        check("t5 restart px", got[19].vec, {24'h000077, 3'b001, 2'd0, 3'd0, 1'b0, 1'b1});
        check_vecs(19, "t5");
        check("t5 sticky", err_frame, 1'b1);
        pulse_clr();
        check("t5 cleared", {err_line, err_frame}, 2'b00);

        // T6: reset mid-frame while output is stalled
        fill_img(0); make_vecs(); got.delete();
        send_range(0, 11);
        m_tready = 1'b0; acc_cnt = 0;
        s_tdata = 8'h14; s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b1;
        repeat (6) @(negedge clk);
        check("t6 stalled accepts<=2", acc_cnt <= 2, 1'b1);
        check("t6 stalled tvalid", m_tvalid, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("t6 rst tvalid", m_tvalid, 1'b0);
        check("t6 rst tready", s_tready, 1'b0);
        @(negedge clk);
        rstn = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1; got.delete();
        @(negedge clk);
        fill_img(8'h80); make_vecs();
        send(8'h55, 1'b0, 1'b0); send(8'h56, 1'b0, 1'b0);
        send_range(0, 31);
        wait_out(32, "t6");
        check_vecs(0, "t6");
        check("t6 row0 taps", got[2].vec[33:10], 24'h000082);
        check("t6 errors", {err_line, err_frame}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
